rf_write_arbiter: RTL and testbench

- Shares the register file's single write port between the writeback path and the post-increment path, so the two sources no longer race on the same clock edge.
- Sits between the writeback/post-increment logic and the register file write port.
- Issues one write per cycle and parks the rest in a small coalescing pending queue.
- Forwards pending data onto the register read path and stalls the core when the queue nears full.

---
 rtl/rf_write_arbiter_pkg.sv | 24 ++
 rtl/rf_write_arbiter_if.sv | 41 ++++
 rtl/rf_write_arbiter_pend_queue.sv | 146 ++++++++++++++
 rtl/rf_write_arbiter.sv | 151 +++++++++++++++
 tb/tb_rf_write_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Contents:
//   XLEN_C / AW_C  - default data and register-address widths
//   pend_entry_t   - one pending-queue entry {valid, addr, data}
//   req_src_e      - which source owns the write port in a given cycle
package rf_arb_pkg;

    localparam int XLEN_C = 32;
    localparam int AW_C   = 5;

    typedef struct packed {
        logic              valid;
        logic [AW_C-1:0]   addr;
        logic [XLEN_C-1:0] data;
    } pend_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PEND,
        SRC_WB,
        SRC_PI
    } req_src_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus bundle between the core (writeback, post-increment, register reads)
// and the write arbiter.
//   master: the core side, drives requests, read addresses and raw RF data
//   slave : the arbiter, drives stall, the RF write port and forwarded data
interface rf_write_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int XLEN = XLEN_C,
    parameter int AW   = AW_C
) ();

    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            pi_en;
    logic [AW-1:0]   pi_addr;
    logic [XLEN-1:0] pi_data;
    logic            stall_o;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [AW-1:0]   rd_addr1;
    logic [AW-1:0]   rd_addr2;
    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;
    logic [XLEN-1:0] fwd_rdata1;
    logic [XLEN-1:0] fwd_rdata2;

    modport master (
        output wb_en, wb_addr, wb_data, pi_en, pi_addr, pi_data,
        output rd_addr1, rd_addr2, rf_rdata1, rf_rdata2,
        input  stall_o, rf_we, rf_waddr, rf_wdata, fwd_rdata1, fwd_rdata2
    );

    modport slave (
        input  wb_en, wb_addr, wb_data, pi_en, pi_addr, pi_data,
        input  rd_addr1, rd_addr2, rf_rdata1, rf_rdata2,
        output stall_o, rf_we, rf_waddr, rf_wdata, fwd_rdata1, fwd_rdata2
    );

endinterface

// File: rtl/rf_write_arbiter_pend_queue.sv
// rf_pend_queue: circular buffer of pending register writes with an address CAM.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   pop                      - retire the head entry
//   push0_* / push1_*        - append up to two entries, push0 lands first
//   upd0_* / upd1_*          - overwrite data of an existing entry by index
//   head_*                   - head entry peek and its index
//   count                    - registered occupancy
//   cam0_* / cam1_*          - address match returning entry index
//   lk0_* / lk1_*            - address match returning entry data (forwarding)
module rf_pend_queue
    import rf_arb_pkg::*;
#(
    parameter int XLEN  = XLEN_C,
    parameter int AW    = AW_C,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pop,
    input  logic            push0_en,
    input  logic [AW-1:0]   push0_addr,
    input  logic [XLEN-1:0] push0_data,
    input  logic            push1_en,
    input  logic [AW-1:0]   push1_addr,
    input  logic [XLEN-1:0] push1_data,
    input  logic            upd0_en,
    input  logic [PW-1:0]   upd0_idx,
    input  logic [XLEN-1:0] upd0_data,
    input  logic            upd1_en,
    input  logic [PW-1:0]   upd1_idx,
    input  logic [XLEN-1:0] upd1_data,
    output logic            head_valid,
    output logic [PW-1:0]   head_idx,
    output logic [AW-1:0]   head_addr,
    output logic [XLEN-1:0] head_data,
    output logic [CW-1:0]   count,
    input  logic [AW-1:0]   cam0_key,
    output logic            cam0_hit,
    output logic [PW-1:0]   cam0_idx,
    input  logic [AW-1:0]   cam1_key,
    output logic            cam1_hit,
    output logic [PW-1:0]   cam1_idx,
    input  logic [AW-1:0]   lk0_addr,
    output logic            lk0_hit,
    output logic [XLEN-1:0] lk0_data,
    input  logic [AW-1:0]   lk1_addr,
    output logic            lk1_hit,
    output logic [XLEN-1:0] lk1_data
);

    logic            valid_q [DEPTH];
    logic [AW-1:0]   addr_q  [DEPTH];
    logic [XLEN-1:0] data_q  [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   push1_slot;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // The second push follows the first when both fire in one cycle.
    assign push1_slot = push0_en ? ptr_inc(wr_ptr) : wr_ptr;

    // Pushes are applied after the pop clear; the arbiter's stall threshold
    // guarantees they never land on the slot being popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= ptr_inc(rd_ptr);
            end
            if (upd0_en) begin
                data_q[upd0_idx] <= upd0_data;
            end
            if (upd1_en) begin
                data_q[upd1_idx] <= upd1_data;
            end
            if (push0_en) begin
                valid_q[wr_ptr] <= 1'b1;
                addr_q[wr_ptr]  <= push0_addr;
                data_q[wr_ptr]  <= push0_data;
            end
            if (push1_en) begin
                valid_q[push1_slot] <= 1'b1;
                addr_q[push1_slot]  <= push1_addr;
                data_q[push1_slot]  <= push1_data;
            end
            if (push1_en) begin
                wr_ptr <= ptr_inc(push1_slot);
            end else if (push0_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            count_q <= count_q + CW'(push0_en) + CW'(push1_en) - CW'(pop);
        end
    end

    assign head_valid = (count_q != '0);
    assign head_idx   = rd_ptr;
    assign head_addr  = addr_q[rd_ptr];
    assign head_data  = data_q[rd_ptr];
    assign count      = count_q;

    // Pending addresses are unique, so at most one entry matches each key.
    always_comb begin
        cam0_hit = 1'b0;
        cam0_idx = '0;
        cam1_hit = 1'b0;
        cam1_idx = '0;
        lk0_hit  = 1'b0;
        lk0_data = '0;
        lk1_hit  = 1'b0;
        lk1_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == cam0_key) begin
                cam0_hit = 1'b1;
                cam0_idx = PW'(i);
            end
            if (valid_q[i] && addr_q[i] == cam1_key) begin
                cam1_hit = 1'b1;
                cam1_idx = PW'(i);
            end
            if (valid_q[i] && addr_q[i] == lk0_addr) begin
                lk0_hit  = 1'b1;
                lk0_data = data_q[i];
            end
            if (valid_q[i] && addr_q[i] == lk1_addr) begin
                lk1_hit  = 1'b1;
                lk1_data = data_q[i];
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single write port between the
// writeback (wb) and post-increment (pi) paths.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of rf_write_arbiter_if: wb/pi requests, stall_o,
//              RF write port, read addresses, raw and forwarded read data
// One write issues per cycle (pending head, then wb, then pi); the rest are
// coalesced into a small pending queue whose contents are forwarded to reads.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int XLEN  = XLEN_C,
    parameter int AW    = AW_C,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    rf_write_arbiter_if.slave bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - 1);

    req_src_e        src;
    logic            stall;
    logic            wb_ok, pi_ok, wb_q, pi_q, wb_hit, pi_hit;
    logic            we_c;
    logic [AW-1:0]   waddr_c;
    logic [XLEN-1:0] wdata_c;

    logic            head_valid;
    logic [PW-1:0]   head_idx;
    logic [AW-1:0]   head_addr;
    logic [XLEN-1:0] head_data;
    logic [CW-1:0]   count;
    logic            cam0_hit, cam1_hit, lk0_hit, lk1_hit;
    logic [PW-1:0]   cam0_idx, cam1_idx;
    logic [XLEN-1:0] lk0_data, lk1_data;

    // Stall looks only at registered occupancy: no path from the request enables.
    assign stall = !rst && (count >= STALL_AT);

    // Filter requests, resolve the same-address conflict (pi is architecturally
    // last, so it wins) and pick the single source that owns the write port.
    // A request that matches the head being issued must not coalesce into it,
    // because that entry is leaving the queue this cycle.
    always_comb begin
        wb_ok = bus.wb_en && (bus.wb_addr != '0) && !stall && !rst;
        pi_ok = bus.pi_en && (bus.pi_addr != '0) && !stall && !rst;
        if (wb_ok && pi_ok && (bus.wb_addr == bus.pi_addr)) begin
            wb_ok = 1'b0;
        end

        src = SRC_NONE;
        if (head_valid && !rst) begin
            src = SRC_PEND;
        end else if (wb_ok) begin
            src = SRC_WB;
        end else if (pi_ok) begin
            src = SRC_PI;
        end

        wb_q   = wb_ok && (src != SRC_WB);
        pi_q   = pi_ok && (src != SRC_PI);
        wb_hit = cam0_hit && !((src == SRC_PEND) && (cam0_idx == head_idx));
        pi_hit = cam1_hit && !((src == SRC_PEND) && (cam1_idx == head_idx));

        we_c    = 1'b0;
        waddr_c = '0;
        wdata_c = '0;
        case (src)
            SRC_PEND: begin
                we_c    = 1'b1;
                waddr_c = head_addr;
                wdata_c = head_data;
            end
            SRC_WB: begin
                we_c    = 1'b1;
                waddr_c = bus.wb_addr;
                wdata_c = bus.wb_data;
            end
            SRC_PI: begin
                we_c    = 1'b1;
                waddr_c = bus.pi_addr;
                wdata_c = bus.pi_data;
            end
            default: ;
        endcase
    end

    // The issuing head is still a pending entry, so the queue lookup alone
    // covers it; fresh requests are deliberately invisible to reads.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [AW-1:0]   a,
        input logic            hit,
        input logic [XLEN-1:0] pend_d,
        input logic [XLEN-1:0] raw
    );
        if (a == '0) return '0;
        if (hit)     return pend_d;
        return raw;
    endfunction

    assign bus.stall_o    = stall;
    assign bus.rf_we      = we_c;
    assign bus.rf_waddr   = waddr_c;
    assign bus.rf_wdata   = wdata_c;
    assign bus.fwd_rdata1 = fwd_sel(bus.rd_addr1, lk0_hit && !rst, lk0_data, bus.rf_rdata1);
    assign bus.fwd_rdata2 = fwd_sel(bus.rd_addr2, lk1_hit && !rst, lk1_data, bus.rf_rdata2);

    rf_pend_queue #(
        .XLEN  (XLEN),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .pop        (src == SRC_PEND),
        .push0_en   (wb_q && !wb_hit),
        .push0_addr (bus.wb_addr),
        .push0_data (bus.wb_data),
        .push1_en   (pi_q && !pi_hit),
        .push1_addr (bus.pi_addr),
        .push1_data (bus.pi_data),
        .upd0_en    (wb_q && wb_hit),
        .upd0_idx   (cam0_idx),
        .upd0_data  (bus.wb_data),
        .upd1_en    (pi_q && pi_hit),
        .upd1_idx   (cam1_idx),
        .upd1_data  (bus.pi_data),
        .head_valid (head_valid),
        .head_idx   (head_idx),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (count),
        .cam0_key   (bus.wb_addr),
        .cam0_hit   (cam0_hit),
        .cam0_idx   (cam0_idx),
        .cam1_key   (bus.pi_addr),
        .cam1_hit   (cam1_hit),
        .cam1_idx   (cam1_idx),
        .lk0_addr   (bus.rd_addr1),
        .lk0_hit    (lk0_hit),
        .lk0_data   (lk0_data),
        .lk1_addr   (bus.rd_addr2),
        .lk1_hit    (lk1_hit),
        .lk1_data   (lk1_data)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter. A behavioural model keeps the pending writes
// as an ordered list plus two register images: what the register file holds
// (model_rf) and the architecturally latest value of each register (arch).
// Forwarded reads must equal arch; issued writes follow list order.
module tb_rf_write_arbiter;
    import rf_arb_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    rf_write_arbiter_if #(.XLEN(32), .AW(5)) bus ();

    rf_write_arbiter #(
        .XLEN  (32),
        .AW    (5),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pend_entry_t pend[$];
    logic [31:0] model_rf [32];
    logic [31:0] arch     [32];
    logic [31:0] dut_rf   [32];
    int total;
    int bad;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Later writes to a pending address replace its data; otherwise append.
    function automatic void modelEnqueue(input logic [4:0] a, input logic [31:0] d);
        foreach (pend[i]) begin
            if (pend[i].addr == a) begin
                pend[i].data = d;
                return;
            end
        end
        pend.push_back('{1'b1, a, d});
    endfunction

    // One clock cycle: drive requests and reads, check every output against
    // the model, then advance the model past the coming edge.
    task automatic applyStimulus(
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic pe, input logic [4:0] pa, input logic [31:0] pd,
        input logic [4:0] r1, input logic [4:0] r2
    );
        logic        exp_stall, wok, pok, wb_issued, pi_issued, exp_we;
        logic [4:0]  exp_a;
        logic [31:0] exp_d, exp_f1, exp_f2;
        pend_entry_t head;

        @(negedge clk);
        bus.wb_en     = we;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        bus.pi_en     = pe;
        bus.pi_addr   = pa;
        bus.pi_data   = pd;
        bus.rd_addr1  = r1;
        bus.rd_addr2  = r2;
        bus.rf_rdata1 = model_rf[r1];
        bus.rf_rdata2 = model_rf[r2];
        #1;

        exp_stall = (pend.size() >= DEPTH - 1);
        checkOutput("stall_o", 64'(bus.stall_o), 64'(exp_stall));

        wok = we && (wa != 5'd0) && !exp_stall;
        pok = pe && (pa != 5'd0) && !exp_stall;
        if (wok && pok && wa == pa) wok = 1'b0;

        exp_f1 = (r1 == 5'd0) ? 32'd0 : arch[r1];
        exp_f2 = (r2 == 5'd0) ? 32'd0 : arch[r2];

        exp_we    = 1'b0;
        exp_a     = 5'd0;
        exp_d     = 32'd0;
        wb_issued = 1'b0;
        pi_issued = 1'b0;
        if (pend.size() > 0) begin
            head   = pend.pop_front();
            exp_we = 1'b1;
            exp_a  = head.addr;
            exp_d  = head.data;
        end else if (wok) begin
            exp_we    = 1'b1;
            exp_a     = wa;
            exp_d     = wd;
            wb_issued = 1'b1;
        end else if (pok) begin
            exp_we    = 1'b1;
            exp_a     = pa;
            exp_d     = pd;
            pi_issued = 1'b1;
        end

        checkOutput("rf_we", 64'(bus.rf_we), 64'(exp_we));
        if (exp_we) begin
            checkOutput("rf_waddr", 64'(bus.rf_waddr), 64'(exp_a));
            checkOutput("rf_wdata", 64'(bus.rf_wdata), 64'(exp_d));
        end
        if (!((wb_issued || pi_issued) && r1 == exp_a))
            checkOutput("fwd_rdata1", 64'(bus.fwd_rdata1), 64'(exp_f1));
        if (!((wb_issued || pi_issued) && r2 == exp_a))
            checkOutput("fwd_rdata2", 64'(bus.fwd_rdata2), 64'(exp_f2));

        if (wok && !wb_issued) modelEnqueue(wa, wd);
        if (pok && !pi_issued) modelEnqueue(pa, pd);
        if (wok) arch[wa] = wd;
        if (pok) arch[pa] = pd;
        if (exp_we) model_rf[exp_a] = exp_d;
        if (bus.rf_we) dut_rf[bus.rf_waddr] = bus.rf_wdata;
    endtask

    task automatic idleCycle(input logic [4:0] r1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, 5'd0);
    endtask

    // One reset cycle: outputs are forced quiet and pending writes are lost.
    task automatic applyReset();
        logic [4:0] r1;
        r1 = 5'($urandom_range(1, 31));
        @(negedge clk);
        rst           = 1'b1;
        bus.wb_en     = 1'b0;
        bus.pi_en     = 1'b0;
        bus.rd_addr1  = r1;
        bus.rd_addr2  = 5'd0;
        bus.rf_rdata1 = model_rf[r1];
        bus.rf_rdata2 = 32'hDEAD_BEEF;
        #1;
        checkOutput("rst_rf_we", 64'(bus.rf_we), 64'd0);
        checkOutput("rst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
        checkOutput("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
        checkOutput("rst_stall_o", 64'(bus.stall_o), 64'd0);
        checkOutput("rst_fwd1", 64'(bus.fwd_rdata1), 64'(model_rf[r1]));
        checkOutput("rst_fwd2", 64'(bus.fwd_rdata2), 64'd0);
        pend.delete();
        for (int i = 0; i < 32; i++) arch[i] = model_rf[i];
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.wb_en = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
        bus.pi_en = 1'b0; bus.pi_addr = 5'd0; bus.pi_data = 32'd0;
        bus.rd_addr1 = 5'd0; bus.rd_addr2 = 5'd0;
        bus.rf_rdata1 = 32'd0; bus.rf_rdata2 = 32'd0;
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = $urandom;
            arch[i]     = model_rf[i];
            dut_rf[i]   = model_rf[i];
        end

        applyReset();
        applyReset();

        $display("[TB] lone request");
        applyStimulus(1'b1, 5'd5, 32'hAAAA_0001, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        idleCycle(5'd5);

        $display("[TB] two sources, different addresses");
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h20, 5'd7, 5'd3);
        idleCycle(5'd7);
        idleCycle(5'd7);

        $display("[TB] two sources, same address");
        applyStimulus(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 32'h104, 5'd9, 5'd0);
        idleCycle(5'd9);

        $display("[TB] stall and drain");
        for (int k = 0; k < 8; k++)
            applyStimulus(1'b1, 5'(16 + k), $urandom, 1'b1, 5'(24 + k), $urandom, 5'd16, 5'd24);
        for (int k = 0; k < 6; k++) idleCycle(5'(24 + k));

        $display("[TB] coalescing and address 0");
        applyStimulus(1'b1, 5'd10, 32'hA, 1'b1, 5'd11, 32'hB, 5'd4, 5'd11);
        applyStimulus(1'b1, 5'd12, 32'hC, 1'b1, 5'd4, 32'd1, 5'd4, 5'd12);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd2, 5'd4, 5'd12);
        idleCycle(5'd4);
        idleCycle(5'd4);
        applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        $display("[TB] reset with pending entries");
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, 5'(13 + k), $urandom, 1'b1, 5'(20 + k), $urandom, 5'd20, 5'd21);
        applyReset();
        for (int k = 0; k < 4; k++) idleCycle(5'(20 + k));

        $display("[TB] randomized traffic");
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                applyReset();
            end else begin
                applyStimulus(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                              1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end
        for (int k = 0; k < 8; k++) idleCycle(5'(k));

        for (int i = 1; i < 32; i++)
            checkOutput("rf_final", 64'(dut_rf[i]), 64'(arch[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
